// File: rtl/system_cpu_debug_jtag_pkg.sv
// rtl/system_cpu_debug_jtag_pkg.sv - shared types and constants for the debug virtual-JTAG master
package system_cpu_debug_jtag_pkg;

    localparam int SR_W = 38;
    localparam int IR_W = 2;

    localparam logic [IR_W-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [IR_W-1:0] IR_TRACECTRL = 2'd1;
    localparam logic [IR_W-1:0] IR_BREAK     = 2'd2;
    localparam logic [IR_W-1:0] IR_TRACEMEM  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RSP
    } jtag_state_e;

endpackage

// File: rtl/system_cpu_debug_jtag_tckgen.sv
// rtl/system_cpu_debug_jtag_tckgen.sv - tck divider: low phase then high phase, TCK_DIV clk cycles each
module system_cpu_debug_jtag_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic fall_tick,
    output logic pre_rise_tick
);

    localparam int CNT_W = $clog2(2 * TCK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(2 * TCK_DIV - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tck_q;

    // tck is registered so it is glitch-free; it mirrors (cnt >= TCK_DIV)
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt   <= '0;
            tck_q <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            tck_q <= (cnt >= LOW_LAST);
        end
    end

    assign tck = tck_q;
    // fall_tick flags the cycle whose closing edge starts the next low phase
    assign fall_tick     = run && (cnt == LAST);
    assign pre_rise_tick = run && (cnt == LOW_LAST);

endmodule

// File: rtl/system_cpu_debug_jtag_master.sv
// rtl/system_cpu_debug_jtag_master.sv - fabric-side host driving the debug slave's virtual-JTAG port
module system_cpu_debug_jtag_master
    import system_cpu_debug_jtag_pkg::*;
#(
    parameter int TCK_DIV     = 2,
    parameter int UPDATE_HOLD = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [SR_W-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SR_W-1:0] rsp_data,
    output logic [IR_W-1:0] rsp_ir_out,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [IR_W-1:0] ir_in,
    input  logic [IR_W-1:0] ir_out,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_udr,
    output logic            jtag_state_rti
);

    jtag_state_e     state, state_next;
    logic [5:0]      per_cnt;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] cap;
    logic [IR_W-1:0] ir_in_q;
    logic [IR_W-1:0] rsp_ir_out_q;
    logic            run;
    logic            fall_tick;
    logic            pre_rise_tick;
    logic            accept;

    system_cpu_debug_jtag_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .tck           (tck),
        .fall_tick     (fall_tick),
        .pre_rise_tick (pre_rise_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        run            = 1'b0;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        jtag_state_rti = 1'b0;
        rsp_valid      = 1'b0;
        cmd_ready      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                jtag_state_rti = 1'b1;
                cmd_ready      = !reset;
                if (cmd_valid) state_next = ST_UIR;
            end
            ST_UIR: begin
                run    = 1'b1;
                vs_uir = 1'b1;
                if (fall_tick) state_next = ST_CDR;
            end
            ST_CDR: begin
                run    = 1'b1;
                vs_cdr = 1'b1;
                if (fall_tick) state_next = ST_SDR;
            end
            ST_SDR: begin
                run    = 1'b1;
                vs_sdr = 1'b1;
                if (fall_tick && per_cnt == 6'(SR_W - 1)) state_next = ST_UDR;
            end
            ST_UDR: begin
                run    = 1'b1;
                vs_udr = 1'b1;
                if (fall_tick && per_cnt == 6'(UPDATE_HOLD - 1)) state_next = ST_RSP;
            end
            ST_RSP: begin
                jtag_state_rti = 1'b1;
                rsp_valid      = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept = (state == ST_IDLE) && cmd_valid;

    // per_cnt counts completed tck periods within the current state
    always_ff @(posedge clk) begin
        if (reset || state_next != state) begin
            per_cnt <= '0;
        end else if (fall_tick) begin
            per_cnt <= per_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            cap          <= '0;
            ir_in_q      <= '0;
            rsp_ir_out_q <= '0;
        end else begin
            if (accept) begin
                ir_in_q <= cmd_ir;
                sr      <= cmd_data;
                cap     <= '0;
            end
            if (state == ST_UIR && pre_rise_tick) begin
                rsp_ir_out_q <= ir_out;
            end
            // tdo is sampled just before the rise, sr advances as tck falls
            if (state == ST_SDR && pre_rise_tick) begin
                cap <= {tdo, cap[SR_W-1:1]};
            end
            if (state == ST_SDR && fall_tick) begin
                sr <= {1'b0, sr[SR_W-1:1]};
            end
        end
    end

    assign tdi        = (state == ST_SDR) ? sr[0] : 1'b0;
    assign ir_in      = ir_in_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign rsp_data   = cap;

endmodule
